// File: rtl/discriminator_seq.sv
// discriminator_seq: 9-3-1 GAN discriminator on one shared Q(WIDTH-FRAC).FRAC MAC, valid/ready on x_pix in and score/is_real out, busy when not idle; define DISC_SAT_EN for saturating arithmetic
module discriminator_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC = 16,
  parameter int N_PIX = 9,
  parameter int N_HID = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_PIX*WIDTH-1:0]          x_pix,
  input  logic [N_PIX*N_HID*WIDTH-1:0]    w_D1,
  input  logic [N_HID*WIDTH-1:0]          b_D1,
  input  logic [N_HID*WIDTH-1:0]          w_D2,
  input  logic [WIDTH-1:0]                b_D2,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [WIDTH-1:0]         score,
  output logic                            is_real,
  output logic                            busy
);
  localparam int KW = $clog2(N_PIX);
  localparam int HW = $clog2(N_HID);
`ifdef DISC_SAT_EN
  localparam logic signed [2*WIDTH-1:0] PMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] PMIN = ~PMAX;
`endif
  typedef enum logic [2:0] {IDLE, L1_MAC, L1_ACT, L2_MAC, L2_ACT, DONE} state_t;
  state_t st, nxt;
  logic [N_PIX*WIDTH-1:0] x_r;
  logic signed [WIDTH-1:0] acc, ma, mb, prod, bias, sum;
  logic signed [WIDTH-1:0] hid [N_HID];
  logic [KW-1:0] k;
  logic [HW-1:0] h;
  logic k_last, h_last, mac;

  function automatic logic signed [WIDTH-1:0] mulq(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b);
`ifdef DISC_SAT_EN
    logic signed [2*WIDTH-1:0] p;
    p = ((2*WIDTH)'(a) * (2*WIDTH)'(b)) >>> FRAC;
    return p > PMAX ? PMAX[WIDTH-1:0] : p < PMIN ? PMIN[WIDTH-1:0] : p[WIDTH-1:0];
`else
    return WIDTH'(((2*WIDTH)'(a) * (2*WIDTH)'(b)) >>> FRAC);
`endif
  endfunction

  function automatic logic signed [WIDTH-1:0] addw(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b);
`ifdef DISC_SAT_EN
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    return s[WIDTH] != s[WIDTH-1] ? {s[WIDTH], {(WIDTH-1){!s[WIDTH]}}} : s[WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  assign k_last = k == KW'(N_PIX-1);
  assign h_last = h == HW'(N_HID-1);
  assign mac = st == L1_MAC || st == L2_MAC;
  assign in_ready = st == IDLE;
  assign busy = st != IDLE;
  assign out_valid = st == DONE;

  always_comb begin
    ma = st == L2_MAC ? hid[h] : x_r[int'(k)*WIDTH +: WIDTH];
    mb = st == L2_MAC ? w_D2[int'(h)*WIDTH +: WIDTH] : w_D1[(N_PIX*int'(h)+int'(k))*WIDTH +: WIDTH];
    bias = st == L2_ACT ? b_D2 : b_D1[int'(h)*WIDTH +: WIDTH];
    prod = mulq(ma, mb);
    sum = addw(acc, mac ? prod : bias);
  end

  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = in_valid ? L1_MAC : IDLE;
      L1_MAC:  nxt = k_last ? L1_ACT : L1_MAC;
      L1_ACT:  nxt = h_last ? L2_MAC : L1_MAC;
      L2_MAC:  nxt = h_last ? L2_ACT : L2_MAC;
      L2_ACT:  nxt = DONE;
      DONE:    nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) st <= rst ? IDLE : nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      k <= '0;
      h <= '0;
      x_r <= '0;
      score <= '0;
      is_real <= 1'b0;
      for (int i = 0; i < N_HID; i++) hid[i] <= '0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          x_r <= x_pix;
          acc <= '0;
          k <= '0;
          h <= '0;
        end
        L1_MAC: begin
          acc <= sum;
          k <= k_last ? '0 : k + KW'(1);
        end
        L1_ACT: begin
          hid[h] <= sum[WIDTH-1] ? '0 : sum;
          acc <= '0;
          h <= h_last ? '0 : h + HW'(1);
        end
        L2_MAC: begin
          acc <= sum;
          h <= h_last ? '0 : h + HW'(1);
        end
        L2_ACT: begin
          score <= sum;
          is_real <= !sum[WIDTH-1] && sum != '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_discriminator_seq.sv
// tb_discriminator_seq: directed vector table plus handshake, backpressure, reset and back-to-back sequences for discriminator_seq
module tb_discriminator_seq;
  localparam int W = 32;
  localparam logic [31:0] ONE = 32'h0001_0000;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [9*W-1:0] x_pix = '0;
  logic [27*W-1:0] w_D1 = '0;
  logic [3*W-1:0] b_D1 = '0, w_D2 = '0;
  logic [W-1:0] b_D2 = '0;
  logic in_ready, out_valid, is_real, busy;
  logic signed [W-1:0] score;
  int passed = 0, total = 0;

  typedef struct {
    logic [31:0] x, w1, b1, w2, b2, exp_score;
    logic exp_real;
  } vec_t;
  vec_t vt [7];

  always #5 clk = ~clk;

  discriminator_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_pix(x_pix),
    .w_D1(w_D1), .b_D1(b_D1), .w_D2(w_D2), .b_D2(b_D2), .out_valid(out_valid),
    .out_ready(out_ready), .score(score), .is_real(is_real), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] mq(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    p = p >>> 16;
`ifdef DISC_SAT_EN
    if (p > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (p < -64'sh8000_0000) return 32'h8000_0000;
`endif
    return p[31:0];
  endfunction

  function automatic logic [31:0] ad(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
`ifdef DISC_SAT_EN
    if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return s[31:0];
  endfunction

  function automatic logic [31:0] model(input vec_t v);
    logic [31:0] hv, sv;
    hv = '0;
    for (int k = 0; k < 9; k++) hv = ad(hv, mq(v.x, v.w1));
    hv = ad(hv, v.b1);
    if (hv[31]) hv = '0;
    sv = '0;
    for (int j = 0; j < 3; j++) sv = ad(sv, mq(hv, v.w2));
    return ad(sv, v.b2);
  endfunction

  task automatic set_uniform(input vec_t v);
    x_pix = {9{v.x}};
    w_D1 = {27{v.w1}};
    b_D1 = {3{v.b1}};
    w_D2 = {3{v.w2}};
    b_D2 = v.b2;
  endtask

  task automatic start_frame();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n, a1, a2;
    logic pre;
    logic [31:0] s1, s2;
    vec_t v2;
    vt[0] = '{ONE, ONE, 32'h0, ONE, 32'h0, 32'h001B_0000, 1'b1};
    vt[1] = '{ONE, 32'hFFFF_0000, 32'h0, ONE, 32'hFFFF_8000, 32'hFFFF_8000, 1'b0};
    vt[2] = '{ONE, 32'hFFFF_0000, 32'h0, ONE, 32'h0, 32'h0, 1'b0};
    vt[3] = '{32'h0000_8000, ONE, 32'hFFFF_0000, 32'hFFFF_0000, ONE, 32'hFFF6_8000, 1'b0};
    vt[4] = '{32'h0002_0000, 32'h0000_4000, 32'h0000_8000, 32'h0000_8000, 32'h0, 32'h0007_8000, 1'b1};
    vt[5] = '{32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_0010, 32'h0000_8000, 32'h0, 32'h0000_0009, 1'b1};
`ifdef DISC_SAT_EN
    vt[6] = '{32'h7530_0000, ONE, 32'h0, ONE, 32'h0, 32'h7FFF_FFFF, 1'b1};
`else
    vt[6] = '{32'h7530_0000, ONE, 32'h0, ONE, 32'h0, 32'h5C10_0000, 1'b1};
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_score", score, 32'd0);
    chk("rst_is_real", 32'(is_real), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_uniform(vt[i]);
      start_frame();
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      wait_out(n);
      chk($sformatf("v%0d_latency", i), 32'(n), 32'd34);
      chk($sformatf("v%0d_score", i), score, vt[i].exp_score);
      chk($sformatf("v%0d_is_real", i), 32'(is_real), 32'(vt[i].exp_real));
      chk($sformatf("v%0d_model", i), score, model(vt[i]));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_in_ready_after", i), 32'(in_ready), 32'd1);
      chk($sformatf("v%0d_out_valid_after", i), 32'(out_valid), 32'd0);
    end
    for (int k = 0; k < 9; k++) x_pix[k*W +: W] = ONE * 32'(k + 1);
    w_D1 = '0;
    for (int h = 0; h < 3; h++) w_D1[(9*h + 4*h)*W +: W] = ONE;
    b_D1 = {32'hFFFF_0000, 32'h0, 32'h0};
    w_D2 = {32'h0003_0000, 32'h0002_0000, ONE};
    b_D2 = 32'h0000_8000;
    start_frame();
    wait_out(n);
    chk("idx_latency", 32'(n), 32'd34);
    chk("idx_score", score, 32'h0023_8000);
    chk("idx_is_real", 32'(is_real), 32'd1);
    @(posedge clk);
    #1;
    set_uniform(vt[0]);
    out_ready = 1'b0;
    start_frame();
    wait_out(n);
    chk("bp_latency", 32'(n), 32'd34);
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_score", c), score, 32'h001B_0000);
      chk($sformatf("bp%0d_is_real", c), 32'(is_real), 32'd1);
      chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_no_phantom_busy", 32'(busy), 32'd0);
    start_frame();
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    start_frame();
    wait_out(n);
    chk("midrst_latency", 32'(n), 32'd34);
    chk("midrst_score", score, 32'h001B_0000);
    @(posedge clk);
    #1;
    a1 = -1000;
    a2 = -1000;
    s1 = 32'hDEAD_BEEF;
    s2 = 32'hDEAD_BEEF;
    v2 = vt[0];
    v2.x = 32'h0002_0000;
    in_valid = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      pre = in_ready && in_valid;
      @(posedge clk);
      #1;
      if (pre && a1 < 0) begin
        a1 = c;
        x_pix = {9{v2.x}};
      end else if (pre) begin
        a2 = c;
        in_valid = 1'b0;
      end
      if (out_valid && s1 == 32'hDEAD_BEEF) s1 = score;
      else if (out_valid) s2 = score;
      if (s2 != 32'hDEAD_BEEF) break;
    end
    in_valid = 1'b0;
    chk("b2b_period", 32'(a2 - a1), 32'd36);
    chk("b2b_score1", s1, model(vt[0]));
    chk("b2b_score2", s2, model(v2));
    chk("b2b_score2_const", s2, 32'h0036_0000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
